// File: rtl/arrow_field_scheduler_if.sv
// arrow_field_scheduler_if: frame control, velocity RAM and draw_block signals; master = scheduler, slave = environment
interface arrow_field_scheduler_if #(
  parameter int VEL_ADDRW = 6
);
  logic                 frame_start;
  logic                 busy;
  logic                 frame_done;
  logic                 frame_overrun;
  logic [VEL_ADDRW-1:0] vel_addr;
  logic [95:0]          vel_data;
  logic                 block_start;
  logic                 block_done;
  logic [31:0]          block_x;
  logic [31:0]          block_y;
  logic [31:0]          xn;
  logic [31:0]          yn;
  logic [31:0]          mag;
  modport master (
    input  frame_start, vel_data, block_done,
    output busy, frame_done, frame_overrun, vel_addr, block_start, block_x, block_y, xn, yn, mag
  );
  modport slave (
    output frame_start, vel_data, block_done,
    input  busy, frame_done, frame_overrun, vel_addr, block_start, block_x, block_y, xn, yn, mag
  );
endinterface

// File: rtl/arrow_field_scheduler.sv
// arrow_field_scheduler: walks all tiles in raster order, fetches each tile's velocity and runs one draw_block pass per tile
// ports: clk, rst (sync active-high), bus (arrow_field_scheduler_if.master: frame control, velocity RAM, draw_block operands/handshake)
// ARROW_SKIP_ZERO_EN: when defined, tiles with zero magnitude are skipped without a draw_block pass
module arrow_field_scheduler #(
  parameter int DRAW_WIDTH  = 320,
  parameter int DRAW_HEIGHT = 240,
  parameter int BLOCK_SIZE  = 40,
  parameter int VEL_LATENCY = 2
) (
  input logic clk,
  input logic rst,
  arrow_field_scheduler_if.master bus
);
  localparam int BLOCKS_X   = DRAW_WIDTH / BLOCK_SIZE;
  localparam int BLOCKS_Y   = DRAW_HEIGHT / BLOCK_SIZE;
  localparam int NUM_BLOCKS = BLOCKS_X * BLOCKS_Y;
  localparam int VEL_ADDRW  = $clog2(NUM_BLOCKS);
  localparam int CW         = $clog2(BLOCKS_X + 1);
  localparam logic [31:0]          STEP     = 32'(BLOCK_SIZE) << 16;
  localparam logic [7:0]           LAT_M1   = 8'(VEL_LATENCY - 1);
  localparam logic [VEL_ADDRW-1:0] LAST     = VEL_ADDRW'(NUM_BLOCKS - 1);
  localparam logic [CW-1:0]        LAST_COL = CW'(BLOCKS_X - 1);
  typedef enum logic [2:0] {IDLE, FETCH, LAUNCH, WAIT, NEXT, FIN} state_t;
  state_t      state;
  logic [7:0]  cnt;
  logic [CW-1:0] col;
  logic [31:0] x_acc;
  logic [31:0] y_acc;
  logic        zero_skip;
`ifdef ARROW_SKIP_ZERO_EN
  assign zero_skip = bus.vel_data[31:0] == 32'd0;
`else
  assign zero_skip = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      col               <= '0;
      x_acc             <= '0;
      y_acc             <= '0;
      bus.busy          <= 1'b0;
      bus.frame_done    <= 1'b0;
      bus.frame_overrun <= 1'b0;
      bus.block_start   <= 1'b0;
      bus.vel_addr      <= '0;
      bus.block_x       <= '0;
      bus.block_y       <= '0;
      bus.xn            <= '0;
      bus.yn            <= '0;
      bus.mag           <= '0;
    end else begin
      bus.block_start   <= 1'b0;
      bus.frame_done    <= 1'b0;
      bus.frame_overrun <= bus.frame_start && state != IDLE;
      case (state)
        IDLE: if (bus.frame_start) begin
          state        <= FETCH;
          cnt          <= LAT_M1;
          col          <= '0;
          x_acc        <= '0;
          y_acc        <= '0;
          bus.vel_addr <= '0;
          bus.busy     <= 1'b1;
        end
        FETCH: if (cnt == 8'd0) begin
          bus.xn          <= bus.vel_data[95:64];
          bus.yn          <= bus.vel_data[63:32];
          bus.mag         <= bus.vel_data[31:0];
          bus.block_x     <= x_acc;
          bus.block_y     <= y_acc;
          bus.block_start <= !zero_skip;
          state           <= zero_skip ? NEXT : LAUNCH;
        end else begin
          cnt <= cnt - 1'b1;
        end
        LAUNCH: state <= WAIT;
        WAIT: if (bus.block_done) state <= NEXT;
        NEXT: if (bus.vel_addr == LAST) begin
          state          <= FIN;
          bus.frame_done <= 1'b1;
        end else begin
          col          <= col == LAST_COL ? '0 : col + 1'b1;
          x_acc        <= col == LAST_COL ? '0 : x_acc + STEP;
          y_acc        <= col == LAST_COL ? y_acc + STEP : y_acc;
          bus.vel_addr <= bus.vel_addr + 1'b1;
          cnt          <= LAT_M1;
          state        <= FETCH;
        end
        FIN: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
